// File: rtl/vip_track_pkg.sv
// Shared types and box field layout for the target track filter.
package vip_track_pkg;

    localparam int unsigned BOX_W    = 43;
    localparam int unsigned CRD_W    = 12;
    localparam int unsigned LOST_W   = 4;

    localparam int unsigned XMIN_LSB = 0;
    localparam int unsigned XMIN_MSB = 10;
    localparam int unsigned YMIN_LSB = 11;
    localparam int unsigned YMIN_MSB = 20;
    localparam int unsigned XMAX_LSB = 21;
    localparam int unsigned XMAX_MSB = 31;
    localparam int unsigned YMAX_LSB = 32;
    localparam int unsigned YMAX_MSB = 41;
    localparam int unsigned FLAG_BIT = 42;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HOLD   = 2'd2
    } trk_state_e;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_CAP    = 3'd1,
        SEQ_CHECK  = 3'd2,
        SEQ_FILT   = 3'd3,
        SEQ_COMMIT = 3'd4
    } seq_e;

    typedef struct packed {
        logic        flag;
        logic [9:0]  ymax;
        logic [10:0] xmax;
        logic [9:0]  ymin;
        logic [10:0] xmin;
    } box_t;

    // Split a raw detector word into its box fields.
    function automatic box_t box_unpack(input logic [BOX_W-1:0] v);
        box_t b;
        b.flag = v[FLAG_BIT];
        b.ymax = v[YMAX_MSB:YMAX_LSB];
        b.xmax = v[XMAX_MSB:XMAX_LSB];
        b.ymin = v[YMIN_MSB:YMIN_LSB];
        b.xmin = v[XMIN_MSB:XMIN_LSB];
        return b;
    endfunction

endpackage

// File: rtl/vip_target_track_filter_if.sv
// Detector-side bus of the track filter: measured box in, tracking window and status out.
interface vip_target_track_filter_if;
    import vip_track_pkg::*;

    logic              per_frame_vsync;
    logic [BOX_W-1:0]  meas_pos;
    logic [BOX_W-1:0]  track_pos;
    logic [1:0]        track_state;
    logic [LOST_W-1:0] lost_cnt;
    logic              meas_ok;
    logic              upd_pulse;

    modport slave (
        input  per_frame_vsync,
        input  meas_pos,
        output track_pos,
        output track_state,
        output lost_cnt,
        output meas_ok,
        output upd_pulse
    );

    modport master (
        output per_frame_vsync,
        output meas_pos,
        input  track_pos,
        input  track_state,
        input  lost_cnt,
        input  meas_ok,
        input  upd_pulse
    );
endinterface

// File: rtl/vip_track_axis_ema.sv
// One coordinate of the box smoother: trk + (meas-trk)>>>ALPHA_SHIFT, clamped to [0, lim].
module vip_track_axis_ema
    import vip_track_pkg::*;
#(
    parameter int unsigned ALPHA_SHIFT = 2
) (
    input  logic [CRD_W-1:0] trk_i,
    input  logic [CRD_W-1:0] meas_i,
    input  logic [CRD_W-1:0] lim_i,
    output logic [CRD_W-1:0] crd_o
);

    logic signed [CRD_W-1:0] diff_c;
    logic signed [CRD_W-1:0] diff_sh_c;
    logic signed [CRD_W:0]   sum_c;

    // Arithmetic shift floors toward -inf; the extra sum bit catches underflow.
    always_comb begin
        diff_c    = $signed(meas_i - trk_i);
        diff_sh_c = diff_c >>> ALPHA_SHIFT;
        sum_c     = $signed({1'b0, trk_i}) + $signed({diff_sh_c[CRD_W-1], diff_sh_c});
        if (sum_c[CRD_W]) begin
            crd_o = '0;
        end else if (sum_c[CRD_W-1:0] > lim_i) begin
            crd_o = lim_i;
        end else begin
            crd_o = sum_c[CRD_W-1:0];
        end
    end

endmodule

// File: rtl/vip_target_track_filter.sv
// Per-frame box tracker: validates the detector box after each frame, smooths it and
// drives the next frame's search window through a SEARCH/TRACK/HOLD state machine.
module vip_target_track_filter
    import vip_track_pkg::*;
#(
    parameter int unsigned IMG_HDISP   = 1280,
    parameter int unsigned IMG_VDISP   = 720,
    parameter int unsigned MIN_W       = 4,
    parameter int unsigned MIN_H       = 4,
    parameter int unsigned MAX_W       = 200,
    parameter int unsigned MAX_H       = 200,
    parameter int unsigned MAX_JUMP    = 64,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned LOST_MAX    = 8
) (
    input  logic clk,
    input  logic rst_n,
    vip_target_track_filter_if.slave bus_if
);

    localparam box_t SEARCH_BOX = {1'b1, 10'(IMG_VDISP - 1), 11'(IMG_HDISP - 1), 10'd0, 11'd0};

    logic              vs_q, vs_qq, fall_q;
    seq_e              seq_q;
    box_t              meas_q, ema_q, trk_q;
    logic              size_ok_q, ok_q, meas_ok_q, upd_q;
    trk_state_e        state_q;
    logic [LOST_W-1:0] lost_q;

    logic [CRD_W-1:0]  mw_c, mh_c, cx_m_c, cy_m_c, cx_t_c, cy_t_c, dx_c, dy_c;
    logic              size_ok_c, ok_c;
    logic [CRD_W-1:0]  ex0_c, ey0_c, ex1_c, ey1_c;
    box_t              ema_c;

    // Size and centre-jump validation of the captured box against the tracked box.
    always_comb begin
        mw_c   = CRD_W'(meas_q.xmax) - CRD_W'(meas_q.xmin);
        mh_c   = CRD_W'(meas_q.ymax) - CRD_W'(meas_q.ymin);
        size_ok_c = meas_q.flag
                 && (meas_q.xmax >= meas_q.xmin) && (meas_q.ymax >= meas_q.ymin)
                 && (mw_c >= CRD_W'(MIN_W)) && (mw_c <= CRD_W'(MAX_W))
                 && (mh_c >= CRD_W'(MIN_H)) && (mh_c <= CRD_W'(MAX_H));
        cx_m_c = (CRD_W'(meas_q.xmin) + CRD_W'(meas_q.xmax)) >> 1;
        cy_m_c = (CRD_W'(meas_q.ymin) + CRD_W'(meas_q.ymax)) >> 1;
        cx_t_c = (CRD_W'(trk_q.xmin) + CRD_W'(trk_q.xmax)) >> 1;
        cy_t_c = (CRD_W'(trk_q.ymin) + CRD_W'(trk_q.ymax)) >> 1;
        dx_c   = (cx_m_c >= cx_t_c) ? (cx_m_c - cx_t_c) : (cx_t_c - cx_m_c);
        dy_c   = (cy_m_c >= cy_t_c) ? (cy_m_c - cy_t_c) : (cy_t_c - cy_m_c);
        ok_c   = size_ok_q && ((state_q == ST_SEARCH)
                 || ((dx_c <= CRD_W'(MAX_JUMP)) && (dy_c <= CRD_W'(MAX_JUMP))));
    end

    vip_track_axis_ema #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_xmin (
        .trk_i(CRD_W'(trk_q.xmin)), .meas_i(CRD_W'(meas_q.xmin)),
        .lim_i(CRD_W'(IMG_HDISP - 1)), .crd_o(ex0_c));
    vip_track_axis_ema #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_ymin (
        .trk_i(CRD_W'(trk_q.ymin)), .meas_i(CRD_W'(meas_q.ymin)),
        .lim_i(CRD_W'(IMG_VDISP - 1)), .crd_o(ey0_c));
    vip_track_axis_ema #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_xmax (
        .trk_i(CRD_W'(trk_q.xmax)), .meas_i(CRD_W'(meas_q.xmax)),
        .lim_i(CRD_W'(IMG_HDISP - 1)), .crd_o(ex1_c));
    vip_track_axis_ema #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_ymax (
        .trk_i(CRD_W'(trk_q.ymax)), .meas_i(CRD_W'(meas_q.ymax)),
        .lim_i(CRD_W'(IMG_VDISP - 1)), .crd_o(ey1_c));

    // Reassemble the smoothed box; a collapsed axis takes max = min.
    always_comb begin
        ema_c      = SEARCH_BOX;
        ema_c.flag = 1'b1;
        ema_c.xmin = 11'(ex0_c);
        ema_c.ymin = 10'(ey0_c);
        ema_c.xmax = (ex0_c > ex1_c) ? 11'(ex0_c) : 11'(ex1_c);
        ema_c.ymax = (ey0_c > ey1_c) ? 10'(ey0_c) : 10'(ey1_c);
    end

    // Vsync edge capture, update sequencer and tracking state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            vs_qq     <= 1'b0;
            fall_q    <= 1'b0;
            seq_q     <= SEQ_IDLE;
            meas_q    <= '0;
            ema_q     <= '0;
            size_ok_q <= 1'b0;
            ok_q      <= 1'b0;
            trk_q     <= SEARCH_BOX;
            state_q   <= ST_SEARCH;
            lost_q    <= '0;
            meas_ok_q <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            vs_q   <= bus_if.per_frame_vsync;
            vs_qq  <= vs_q;
            fall_q <= vs_qq & ~vs_q;
            upd_q  <= 1'b0;
            case (seq_q)
                SEQ_IDLE: begin
                    if (fall_q) begin
                        meas_q <= box_unpack(bus_if.meas_pos);
                        seq_q  <= SEQ_CAP;
                    end
                end
                SEQ_CAP: begin
                    size_ok_q <= size_ok_c;
                    seq_q     <= SEQ_CHECK;
                end
                SEQ_CHECK: begin
                    ok_q  <= ok_c;
                    seq_q <= SEQ_FILT;
                end
                SEQ_FILT: begin
                    ema_q <= ema_c;
                    seq_q <= SEQ_COMMIT;
                end
                SEQ_COMMIT: begin
                    seq_q     <= SEQ_IDLE;
                    upd_q     <= 1'b1;
                    meas_ok_q <= ok_q;
                    case (state_q)
                        ST_SEARCH: begin
                            lost_q <= '0;
                            if (ok_q) begin
                                trk_q   <= meas_q;
                                state_q <= ST_TRACK;
                            end else begin
                                trk_q   <= SEARCH_BOX;
                            end
                        end
                        ST_TRACK: begin
                            if (ok_q) begin
                                trk_q  <= ema_q;
                                lost_q <= '0;
                            end else begin
                                lost_q  <= LOST_W'(1);
                                state_q <= ST_HOLD;
                            end
                        end
                        ST_HOLD: begin
                            if (ok_q) begin
                                trk_q   <= ema_q;
                                lost_q  <= '0;
                                state_q <= ST_TRACK;
                            end else if ((lost_q + LOST_W'(1)) >= LOST_W'(LOST_MAX)) begin
                                trk_q   <= SEARCH_BOX;
                                lost_q  <= '0;
                                state_q <= ST_SEARCH;
                            end else begin
                                lost_q  <= lost_q + LOST_W'(1);
                            end
                        end
                        default: begin
                            trk_q   <= SEARCH_BOX;
                            lost_q  <= '0;
                            state_q <= ST_SEARCH;
                        end
                    endcase
                end
                default: seq_q <= SEQ_IDLE;
            endcase
        end
    end

    assign bus_if.track_pos   = trk_q;
    assign bus_if.track_state = state_q;
    assign bus_if.lost_cnt    = lost_q;
    assign bus_if.meas_ok     = meas_ok_q;
    assign bus_if.upd_pulse   = upd_q;

endmodule
